// File: rtl/dmem_access_ctrl.sv
// Load/store front end between the EX/MEM datapath and a word-organised DMEM.
// Handles address decode, bounds/alignment checks, extending loads and RMW sub-word stores.
module dmem_access_ctrl #(
  parameter int          ADDR_W    = 11,
  parameter logic [31:0] BASE_ADDR = 32'h10010000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_sext,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_busy,
  output logic              o_ack,
  output logic              o_err,
  output logic [31:0]       o_rdata,
  output logic              o_DMEM_ena,
  output logic              o_DMEM_W,
  output logic              o_DMEM_R,
  output logic [ADDR_W-1:0] o_DM_addr,
  output logic [31:0]       o_DM_wdata,
  input  logic [31:0]       i_DM_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD,
    S_ST,
    S_RMW_RD,
    S_RMW_WR,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]       w_off;
  logic              w_oob;
  logic              w_misalign;
  logic              w_reqErr;
  logic [31:0]       w_shifted;
  logic [31:0]       w_loadData;
  logic [31:0]       w_mergeData;

  logic [1:0]        r_size;
  logic              r_sext;
  logic [1:0]        r_lane;
  logic [ADDR_W-1:0] r_wordIdx;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic [31:0]       r_merge;
  logic [31:0]       r_rdata;

  // Unsigned wrap makes addresses below BASE_ADDR land in the out-of-range test as well.
  assign w_off      = i_req_addr - BASE_ADDR;
  assign w_oob      = |(w_off >> (ADDR_W + 2));
  assign w_misalign = ((i_req_size == 2'b01) && w_off[0]) ||
                      ((i_req_size == 2'b10) && (w_off[1:0] != 2'b00));
  assign w_reqErr   = w_oob || w_misalign || (i_req_size == 2'b11);

  assign w_shifted = i_DM_rdata >> {r_lane, 3'b000};

  always_comb begin
    w_loadData = i_DM_rdata;
    case (r_size)
      2'b00:   w_loadData = r_sext ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                   : {24'h000000, w_shifted[7:0]};
      2'b01:   w_loadData = r_sext ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                   : {16'h0000, w_shifted[15:0]};
      default: w_loadData = i_DM_rdata;
    endcase
  end

  // Half-word lanes are always 0 or 2 here, so lane[1] alone picks the half.
  always_comb begin
    w_mergeData = i_DM_rdata;
    if (r_size == 2'b00) begin
      w_mergeData[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_mergeData[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_size    <= 2'b00;
      r_sext    <= 1'b0;
      r_lane    <= 2'b00;
      r_wordIdx <= '0;
      r_wdata   <= 32'h0;
      r_err     <= 1'b0;
      r_merge   <= 32'h0;
      r_rdata   <= 32'h0;
    end else begin
      if ((r_state == S_IDLE) && i_req) begin
        r_size    <= i_req_size;
        r_sext    <= i_req_sext;
        r_lane    <= w_off[1:0];
        r_wordIdx <= w_off[ADDR_W+1:2];
        r_wdata   <= i_req_wdata;
        r_err     <= w_reqErr;
      end
      if (r_state == S_LD) begin
        r_rdata <= w_loadData;
      end
      if (r_state == S_RMW_RD) begin
        r_merge <= w_mergeData;
      end
    end
  end

  // DMEM strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    w_next     = r_state;
    o_busy     = 1'b1;
    o_ack      = 1'b0;
    o_err      = 1'b0;
    o_DMEM_ena = 1'b0;
    o_DMEM_W   = 1'b0;
    o_DMEM_R   = 1'b0;
    o_DM_addr  = r_wordIdx;
    o_DM_wdata = 32'h0;
    case (r_state)
      S_IDLE: begin
        o_busy    = 1'b0;
        o_DM_addr = '0;
        if (i_req) begin
          if (w_reqErr) begin
            w_next = S_DONE;
          end else if (!i_req_we) begin
            w_next = S_LD;
          end else if (i_req_size == 2'b10) begin
            w_next = S_ST;
          end else begin
            w_next = S_RMW_RD;
          end
        end
      end
      S_LD: begin
        o_DMEM_ena = 1'b1;
        o_DMEM_R   = 1'b1;
        w_next     = S_DONE;
      end
      S_ST: begin
        o_DMEM_ena = 1'b1;
        o_DMEM_W   = 1'b1;
        o_DM_wdata = r_wdata;
        w_next     = S_DONE;
      end
      S_RMW_RD: begin
        o_DMEM_ena = 1'b1;
        o_DMEM_R   = 1'b1;
        w_next     = S_RMW_WR;
      end
      S_RMW_WR: begin
        o_DMEM_ena = 1'b1;
        o_DMEM_W   = 1'b1;
        o_DM_wdata = r_merge;
        w_next     = S_DONE;
      end
      S_DONE: begin
        o_ack  = 1'b1;
        o_err  = r_err;
        w_next = S_IDLE;
      end
      default: begin
        o_busy    = 1'b0;
        o_DM_addr = '0;
        w_next    = S_IDLE;
      end
    endcase
  end

  assign o_rdata = r_rdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: byte-addressed reference memory plus latency model,
// checked every cycle, with directed load/store/error/reset scenarios.
module tb_dmem_access_ctrl;

  localparam int          ADDR_W = 11;
  localparam int          WORDS  = 2048;
  localparam logic [31:0] BASE   = 32'h10010000;

  logic              clk = 1'b0;
  logic              rst;
  logic              req, reqWe, reqSext;
  logic [1:0]        reqSize;
  logic [31:0]       reqAddr, reqWdata;
  logic              busy, ack, err;
  logic [31:0]       rdata;
  logic              dmemEna, dmemW, dmemR;
  logic [ADDR_W-1:0] dmAddr;
  logic [31:0]       dmWdata, dmRdata;

  int checks = 0;
  int errors = 0;

  dmem_access_ctrl #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_we(reqWe), .i_req_size(reqSize),
    .i_req_sext(reqSext), .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
    .o_busy(busy), .o_ack(ack), .o_err(err), .o_rdata(rdata),
    .o_DMEM_ena(dmemEna), .o_DMEM_W(dmemW), .o_DMEM_R(dmemR),
    .o_DM_addr(dmAddr), .o_DM_wdata(dmWdata), .i_DM_rdata(dmRdata)
  );

  always #5 clk = ~clk;

  // DMEM itself: synchronous write, asynchronous read.
  logic [31:0] dmem [WORDS];
  assign dmRdata = dmem[dmAddr];
  always @(posedge clk) if (dmemEna && dmemW) dmem[dmAddr] <= dmWdata;

  int wPulses = 0, enaCycles = 0, ackCount = 0;
  always @(posedge clk) begin
    if (dmemEna && dmemW) wPulses++;
    if (dmemEna) enaCycles++;
  end
  always @(negedge clk) if (ack) ackCount++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
    end
  endtask

  // Reference model: memory as little-endian bytes, each request as a cycle count to its ack.
  logic [7:0]  refBytes [WORDS*4];
  int          mCycle = 0, mLat = 0, mN = 0, mIdx = 0;
  logic [31:0] mOff = 0, mWdata = 0, mNewWord = 0, mRdata = 0;
  bit          mErr = 0, mWe = 0, mSext = 0;

  function automatic int sizeBytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  task automatic acceptModel();
    int lane;
    mOff   = reqAddr - BASE;
    mN     = sizeBytes(reqSize);
    mErr   = (reqSize == 2'b11) || ((mOff % mN) != 0) || (mOff >= 32'd8192);
    mWe    = reqWe;
    mSext  = reqSext;
    mWdata = reqWdata;
    mIdx   = int'((mOff >> 2) % WORDS);
    mLat   = mErr ? 1 : (!reqWe || reqSize == 2'b10) ? 2 : 3;
    mNewWord = 0;
    if (!mErr) begin
      lane = int'(mOff % 4);
      for (int b = 0; b < 4; b++) begin
        if (b >= lane && b < lane + mN)
          mNewWord[8*b +: 8] = mWdata[8*(b-lane) +: 8];
        else
          mNewWord[8*b +: 8] = refBytes[mIdx*4 + b];
      end
    end
  endtask

  task automatic commitModel();
    logic [31:0] val;
    if (mErr) return;
    if (mWe) begin
      for (int i = 0; i < mN; i++) refBytes[int'(mOff) + i] = mWdata[8*i +: 8];
    end else begin
      val = 0;
      for (int i = 0; i < mN; i++) val[8*i +: 8] = refBytes[int'(mOff) + i];
      if (mSext && mN < 4 && val[8*mN-1]) val = val | (32'hFFFFFFFF << (8*mN));
      mRdata = val;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mCycle = 0;
      mRdata = 0;
    end else if (mCycle == 0) begin
      if (req) begin
        acceptModel();
        mCycle = 1;
      end
    end else if (mCycle == mLat) begin
      mCycle = 0;
    end else begin
      mCycle++;
      if (mCycle == mLat) commitModel();
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    bit active, expAck, memCyc, expW;
    active = (mCycle != 0);
    expAck = active && (mCycle == mLat);
    memCyc = active && !expAck;
    expW   = memCyc && mWe && (mCycle == mLat - 1);
    checkOutput("busy", 32'(busy), 32'(active));
    checkOutput("ack", 32'(ack), 32'(expAck));
    checkOutput("err", 32'(err), 32'(expAck && mErr));
    checkOutput("rdata", rdata, mRdata);
    checkOutput("DMEM_ena", 32'(dmemEna), 32'(memCyc));
    checkOutput("DMEM_W", 32'(dmemW), 32'(expW));
    checkOutput("DMEM_R", 32'(dmemR), 32'(memCyc && !expW));
    checkOutput("DM_addr", 32'(dmAddr), active ? 32'(mIdx) : 32'h0);
    if (expW) checkOutput("DM_wdata", dmWdata, mNewWord);
  end

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sext,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int expLat, output logic [31:0] rdOut, output logic errOut);
    int  cnt;
    bit  gotAck;
    @(negedge clk); #1;
    reqWe = we; reqSize = size; reqSext = sext; reqAddr = addr; reqWdata = wdata; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    cnt = 0; gotAck = 0; rdOut = 32'hx; errOut = 1'bx;
    for (int i = 0; i < 8 && !gotAck; i++) begin
      @(negedge clk);
      cnt++;
      if (ack) begin
        gotAck = 1;
        rdOut  = rdata;
        errOut = err;
      end
    end
    checkOutput("ackLatency", 32'(cnt), 32'(expLat));
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          w0, e0, a0;
    for (int i = 0; i < WORDS; i++) dmem[i] = 32'h0;
    for (int i = 0; i < WORDS*4; i++) refBytes[i] = 8'h0;
    req = 0; reqWe = 0; reqSize = 0; reqSext = 0; reqAddr = 0; reqWdata = 0;
    rst = 1'b1;
    #1;
    checkOutput("resetBusy", 32'(busy), 32'h0);
    checkOutput("resetRdata", rdata, 32'h0);
    checkOutput("resetEna", 32'({dmemEna, dmemW, dmemR}), 32'h0);
    checkOutput("resetAddrData", {dmWdata[31:ADDR_W], dmAddr}, 32'h0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    applyStimulus(1, 2'b10, 0, 32'h10010008, 32'hA1B2C3D4, 2, rd, e);
    checkOutput("swErr", 32'(e), 32'h0);
    checkOutput("swMem", dmem[2], 32'hA1B2C3D4);
    applyStimulus(0, 2'b10, 0, 32'h10010008, 32'h0, 2, rd, e);
    checkOutput("lwData", rd, 32'hA1B2C3D4);
    checkOutput("lwErr", 32'(e), 32'h0);

    applyStimulus(0, 2'b00, 1, 32'h1001000B, 32'h0, 2, rd, e);
    checkOutput("lb", rd, 32'hFFFFFFA1);
    applyStimulus(0, 2'b00, 0, 32'h1001000B, 32'h0, 2, rd, e);
    checkOutput("lbu", rd, 32'h000000A1);
    applyStimulus(0, 2'b01, 1, 32'h1001000A, 32'h0, 2, rd, e);
    checkOutput("lh", rd, 32'hFFFFA1B2);
    applyStimulus(0, 2'b01, 0, 32'h1001000A, 32'h0, 2, rd, e);
    checkOutput("lhu", rd, 32'h0000A1B2);

    w0 = wPulses;
    applyStimulus(1, 2'b00, 0, 32'h10010009, 32'hFFFFFF55, 3, rd, e);
    checkOutput("sbPulses", 32'(wPulses - w0), 32'h1);
    checkOutput("sbMem", dmem[2], 32'hA1B255D4);
    w0 = wPulses;
    applyStimulus(1, 2'b01, 0, 32'h1001000A, 32'hABCD1234, 3, rd, e);
    checkOutput("shPulses", 32'(wPulses - w0), 32'h1);
    checkOutput("shMem", dmem[2], 32'h123455D4);
    checkOutput("rdataAfterStores", rdata, 32'h0000A1B2);

    e0 = enaCycles;
    applyStimulus(0, 2'b10, 0, 32'h10010002, 32'h0, 1, rd, e);
    checkOutput("errLwMisalign", 32'(e), 32'h1);
    applyStimulus(1, 2'b01, 0, 32'h10010001, 32'h0000BEEF, 1, rd, e);
    checkOutput("errShMisalign", 32'(e), 32'h1);
    applyStimulus(1, 2'b10, 0, 32'h10012000, 32'hDEADBEEF, 1, rd, e);
    checkOutput("errSwRange", 32'(e), 32'h1);
    applyStimulus(0, 2'b00, 1, 32'h0000FFFC, 32'h0, 1, rd, e);
    checkOutput("errLbBelowBase", 32'(e), 32'h1);
    checkOutput("errEnaCycles", 32'(enaCycles - e0), 32'h0);
    checkOutput("errRdataKept", rd, 32'h0000A1B2);
    checkOutput("errMemKept", dmem[2], 32'h123455D4);

    // Reset asserted mid-cycle during a load.
    @(negedge clk); #1;
    reqWe = 0; reqSize = 2'b10; reqSext = 0; reqAddr = 32'h10010008; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("midResetBusy", 32'(busy), 32'h0);
    checkOutput("midResetStrobes", 32'({dmemEna, dmemW, dmemR, ack, err}), 32'h0);
    checkOutput("midResetAddr", 32'(dmAddr), 32'h0);
    checkOutput("midResetRdata", rdata, 32'h0);
    @(negedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("postResetIdle", 32'(busy), 32'h0);

    // Reset between the read and write halves of an sb.
    w0 = wPulses;
    @(negedge clk); #1;
    reqWe = 1; reqSize = 2'b00; reqAddr = 32'h10010008; reqWdata = 32'h000000EE; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rmwResetPulses", 32'(wPulses - w0), 32'h0);
    checkOutput("rmwResetMem", dmem[2], 32'h123455D4);

    // req held high: one lw accepted every third edge.
    a0 = ackCount;
    @(negedge clk); #1;
    reqWe = 0; reqSize = 2'b10; reqSext = 0; reqAddr = 32'h10010008; req = 1'b1;
    repeat (9) @(posedge clk);
    #1 req = 1'b0;
    checkOutput("heldAcks", 32'(ackCount - a0), 32'h3);
    repeat (4) @(negedge clk);
    checkOutput("heldRdata", rdata, 32'h123455D4);
    checkOutput("heldIdle", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
